// File: rtl/i2c_target.sv
// I2C target: oversampled START/STOP detection, 7-bit address match, ACKed write bytes.
// Optional read support (tx_data/tx_req, TX state) is enabled by defining I2C_TARGET_READ_EN.
module i2c_target #(
    parameter logic [6:0]  ADDR        = 7'h27,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
`ifdef I2C_TARGET_READ_EN
    input  logic [7:0] tx_data,
    output logic       tx_req,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       addressed,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_ST,
        ADDR_ACK,
        RX,
        RX_ACK,
`ifdef I2C_TARGET_READ_EN
        TX,
`endif
        IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [6:0] shift;
    logic [2:0] bit_cnt;
    logic       sda_drv;
    logic       ack_phase;
    logic       first;
    logic       addr_match;
`ifdef I2C_TARGET_READ_EN
    logic       rd_mode;
    logic       mack;
    logic       load;
    logic [6:0] tx_shift;
`endif

    // Synchronizers reset to the idle-bus level so leaving reset never looks like an edge on SDA
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_det  = scl_s & sda_d & ~sda_s;
    assign stop_det   = scl_s & ~sda_d & sda_s;
    assign addr_match = (shift == ADDR);
    assign sda_out    = sda_drv ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = ADDR_ST;
        end else if (stop_det) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                ADDR_ST: if (scl_rise && bit_cnt == 3'd7) begin
`ifdef I2C_TARGET_READ_EN
                    state_nxt = addr_match ? ADDR_ACK : IGNORE;
`else
                    state_nxt = (addr_match && !sda_s) ? ADDR_ACK : IGNORE;
`endif
                end
                ADDR_ACK: if (scl_fall && ack_phase) begin
`ifdef I2C_TARGET_READ_EN
                    state_nxt = rd_mode ? TX : RX;
`else
                    state_nxt = RX;
`endif
                end
                RX:     if (scl_rise && bit_cnt == 3'd7) state_nxt = RX_ACK;
                RX_ACK: if (scl_fall && ack_phase)       state_nxt = RX;
`ifdef I2C_TARGET_READ_EN
                TX:     if (scl_rise && mack && sda_s)   state_nxt = IGNORE;
`endif
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift     <= '0;
            bit_cnt   <= '0;
            sda_drv   <= 1'b0;
            ack_phase <= 1'b0;
            first     <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
            addressed <= 1'b0;
            busy      <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            rd_mode   <= 1'b0;
            mack      <= 1'b0;
            load      <= 1'b0;
            tx_shift  <= '0;
            tx_req    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            tx_req   <= 1'b0;
`endif
            if (start_det) begin
                bit_cnt   <= '0;
                busy      <= 1'b1;
                addressed <= 1'b0;
                sda_drv   <= 1'b0;
                ack_phase <= 1'b0;
                first     <= 1'b0;
`ifdef I2C_TARGET_READ_EN
                mack      <= 1'b0;
                load      <= 1'b0;
`endif
            end else if (stop_det) begin
                busy      <= 1'b0;
                addressed <= 1'b0;
                sda_drv   <= 1'b0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    ADDR_ST, RX: if (scl_rise) begin
                        shift   <= {shift[5:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (state == RX && bit_cnt == 3'd7) begin
                            rx_data  <= {shift, sda_s};
                            rx_valid <= 1'b1;
                            rx_first <= first;
                            first    <= 1'b0;
                        end
`ifdef I2C_TARGET_READ_EN
                        if (state == ADDR_ST && bit_cnt == 3'd7) rd_mode <= sda_s;
`endif
                    end
                    // First fall after the byte pulls SDA low; the next fall releases it
                    ADDR_ACK, RX_ACK: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_drv   <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            sda_drv   <= 1'b0;
                            ack_phase <= 1'b0;
                            if (state == ADDR_ACK) begin
                                addressed <= 1'b1;
                                first     <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                                if (rd_mode) begin
                                    tx_shift <= tx_data[6:0];
                                    sda_drv  <= ~tx_data[7];
                                    tx_req   <= 1'b1;
                                    mack     <= 1'b0;
                                    load     <= 1'b0;
                                end
`endif
                            end
                        end
                    end
`ifdef I2C_TARGET_READ_EN
                    // mack marks the master-ACK bit slot; load defers the next byte to the following fall
                    TX: if (scl_rise) begin
                        if (mack) begin
                            if (!sda_s) begin
                                load   <= 1'b1;
                                mack   <= 1'b0;
                                tx_req <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) mack <= 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (load) begin
                            tx_shift <= tx_data[6:0];
                            sda_drv  <= ~tx_data[7];
                            load     <= 1'b0;
                        end else if (mack) begin
                            sda_drv <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[5:0], 1'b0};
                            sda_drv  <= ~tx_shift[6];
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master, wired-AND SDA, per-scenario inline checks.
module tb_i2c_target;

    localparam int Q = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    wire  t_sda;
    logic sda_in;
    logic [7:0] rx_data;
    logic rx_valid, rx_first, addressed, busy;
`ifdef I2C_TARGET_READ_EN
    logic [7:0] tx_data = 8'h00;
    logic tx_req;
    int n_txreq = 0;
`endif

    int checks = 0;
    int failures = 0;

    int n_valid = 0;
    int n_drive = 0;
    int n_addr  = 0;
    logic [7:0] v_data [64];
    logic       v_first[64];

    pullup (t_sda);
    assign sda_in = m_sda & t_sda;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h27), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl),
        .sda_in   (sda_in),
        .sda_out  (t_sda),
`ifdef I2C_TARGET_READ_EN
        .tx_data  (tx_data),
        .tx_req   (tx_req),
`endif
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .addressed(addressed),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            v_data[n_valid % 64]  = rx_data;
            v_first[n_valid % 64] = rx_first;
            n_valid = n_valid + 1;
        end
        if (t_sda == 1'b0) n_drive = n_drive + 1;
        if (addressed)     n_addr  = n_addr + 1;
`ifdef I2C_TARGET_READ_EN
        if (tx_req)        n_txreq = n_txreq + 1;
`endif
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start;
        m_sda = 1'b1; scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0;             wait_clk(Q);
        scl = 1'b0;               wait_clk(Q);
    endtask

    task automatic i2c_rstart;
        m_sda = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;  wait_clk(Q);
        scl = 1'b1; wait_clk(2 * Q);
        scl = 1'b0; wait_clk(Q);
    endtask

    // Returns the bus level seen mid-way through the ninth SCL high (0 = ACK)
    task automatic recv_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        scl = 1'b1;   wait_clk(Q);
        b = sda_in;   wait_clk(Q);
        scl = 1'b0;   wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1;
        wait_clk(4);
        checks++; if (t_sda !== 1'b1)    begin failures++; $display("FAIL reset_sda got=%b exp=1", t_sda); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if ({rx_valid, rx_first, addressed, busy} !== 4'b0000)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {rx_valid, rx_first, addressed, busy}); end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_single_write;
        logic ack;
        int base;
        base = n_valid;
        i2c_start;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_start got=%b exp=1", busy); end
        send_byte(8'h4E, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t1_addr_ack got=%b exp=0", ack); end
        checks++; if (addressed !== 1'b1) begin failures++; $display("FAIL t1_addressed got=%b exp=1", addressed); end
        send_byte(8'hA5, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t1_data_ack got=%b exp=0", ack); end
        i2c_stop;
        wait_clk(4);
        checks++; if (n_valid - base !== 1) begin failures++; $display("FAIL t1_valid_count got=%0d exp=1", n_valid - base); end
        checks++; if (v_data[base % 64] !== 8'hA5) begin failures++; $display("FAIL t1_rx_data got=%h exp=a5", v_data[base % 64]); end
        checks++; if (v_first[base % 64] !== 1'b1) begin failures++; $display("FAIL t1_rx_first got=%b exp=1", v_first[base % 64]); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_stop got=%b exp=0", busy); end
        checks++; if (addressed !== 1'b0) begin failures++; $display("FAIL t1_addressed_stop got=%b exp=0", addressed); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL t1_rx_data_hold got=%h exp=a5", rx_data); end
    endtask

    task automatic test_wrong_addr;
        logic ack;
        int bv, bd, ba;
        bv = n_valid; bd = n_drive; ba = n_addr;
        i2c_start;
        send_byte(8'h40, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL t2_nack got=%b exp=1", ack); end
        send_byte(8'h11, ack);
        i2c_stop;
        wait_clk(4);
        checks++; if (n_drive - bd !== 0) begin failures++; $display("FAIL t2_sda_driven got=%0d exp=0", n_drive - bd); end
        checks++; if (n_valid - bv !== 0) begin failures++; $display("FAIL t2_valid_count got=%0d exp=0", n_valid - bv); end
        checks++; if (n_addr - ba !== 0)  begin failures++; $display("FAIL t2_addressed got=%0d exp=0", n_addr - ba); end
    endtask

    task automatic test_multi_byte;
        logic ack;
        logic [7:0] exp_d [3];
        int base;
        exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03;
        base = n_valid;
        i2c_start;
        send_byte(8'h4E, ack);
        for (int i = 0; i < 3; i++) begin
            send_byte(exp_d[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t3_ack%0d got=%b exp=0", i, ack); end
        end
        i2c_stop;
        wait_clk(4);
        checks++; if (n_valid - base !== 3) begin failures++; $display("FAIL t3_valid_count got=%0d exp=3", n_valid - base); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (v_data[(base + i) % 64] !== exp_d[i])
                begin failures++; $display("FAIL t3_data%0d got=%h exp=%h", i, v_data[(base + i) % 64], exp_d[i]); end
            checks++; if (v_first[(base + i) % 64] !== (i == 0))
                begin failures++; $display("FAIL t3_first%0d got=%b exp=%b", i, v_first[(base + i) % 64], i == 0); end
        end
    endtask

    task automatic test_rstart;
        logic ack;
        int base;
        base = n_valid;
        i2c_start;
        send_byte(8'h4E, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_rstart;
        checks++; if (addressed !== 1'b0) begin failures++; $display("FAIL t4_addressed_rstart got=%b exp=0", addressed); end
        send_byte(8'h4E, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t4_addr_ack got=%b exp=0", ack); end
        send_byte(8'h5A, ack);
        i2c_stop;
        wait_clk(4);
        checks++; if (n_valid - base !== 1) begin failures++; $display("FAIL t4_valid_count got=%0d exp=1", n_valid - base); end
        checks++; if (v_data[base % 64] !== 8'h5A) begin failures++; $display("FAIL t4_rx_data got=%h exp=5a", v_data[base % 64]); end
        checks++; if (v_first[base % 64] !== 1'b1) begin failures++; $display("FAIL t4_rx_first got=%b exp=1", v_first[base % 64]); end
    endtask

    task automatic test_reset_during_ack;
        logic ack;
        logic [7:0] a;
        a = 8'h4E;
        i2c_start;
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        m_sda = 1'b1;
        checks++; if (t_sda !== 1'b0) begin failures++; $display("FAIL t5_ack_driving got=%b exp=0", t_sda); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (t_sda !== 1'b1) begin failures++; $display("FAIL t5_sda_released got=%b exp=1", t_sda); end
        checks++; if ({rx_data, rx_valid, rx_first, addressed, busy} !== 12'h000)
            begin failures++; $display("FAIL t5_outputs got=%h exp=000", {rx_data, rx_valid, rx_first, addressed, busy}); end
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        i2c_start;
        send_byte(8'h4E, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t5_ack_after_reset got=%b exp=0", ack); end
        i2c_stop;
        wait_clk(4);
    endtask

`ifdef I2C_TARGET_READ_EN
    task automatic test_read;
        logic ack, b;
        logic [7:0] got;
        int bt;
        bt = n_txreq;
        tx_data = 8'hC3;
        i2c_start;
        send_byte(8'h4F, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t6_addr_ack got=%b exp=0", ack); end
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            got[i] = b;
        end
        send_bit(1'b1);
        checks++; if (t_sda !== 1'b1) begin failures++; $display("FAIL t6_released_after_nack got=%b exp=1", t_sda); end
        i2c_stop;
        wait_clk(4);
        checks++; if (got !== 8'hC3) begin failures++; $display("FAIL t6_tx_bits got=%h exp=c3", got); end
        checks++; if (n_txreq - bt !== 1) begin failures++; $display("FAIL t6_tx_req_count got=%0d exp=1", n_txreq - bt); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_write;
        test_wrong_addr;
        test_multi_byte;
        test_rstart;
        test_reset_during_ack;
`ifdef I2C_TARGET_READ_EN
        test_read;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
